// File: rtl/adder_6_bit_sched.sv
// Round-robin front end that time-shares one combinational adder among NUM_REQ
// requesters and returns each tagged sum on a single valid/ready response channel.
module adder_6_bit_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 6,
  parameter int IDW     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic [WIDTH-1:0]           add_sum,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       busy,
  output logic [15:0]                ops_done
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state_reg, state_next;
  logic [IDW-1:0]    ptr_reg;
  logic [WIDTH-1:0]  op_a_reg, op_b_reg;
  logic [IDW-1:0]    op_id_reg;
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [WIDTH-1:0]  a_arr [NUM_REQ];
  logic [WIDTH-1:0]  b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // Scan from the farthest slot back to ptr so the nearest valid requester wins.
  function automatic logic [IDW:0] pick(input logic [NUM_REQ-1:0] v,
                                        input logic [IDW-1:0] p);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    {grant_found, grant_idx} = pick(req_valid, ptr_reg);
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_reg == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = CALC;
      CALC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Adder inputs are held at zero outside CALC to keep the shared adder quiet.
  assign add_a = (state_reg == CALC) ? op_a_reg : '0;
  assign add_b = (state_reg == CALC) ? op_b_reg : '0;
  assign busy  = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      op_id_reg <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      ops_done  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            op_a_reg  <= a_arr[grant_idx];
            op_b_reg  <= b_arr[grant_idx];
            op_id_reg <= grant_idx;
            ptr_reg   <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        CALC: begin
          rsp_sum   <= add_sum;
          rsp_id    <= op_id_reg;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_6_bit_sched.sv
// Directed bench for adder_6_bit_sched; the shared adder is modelled inline.
module tb_adder_6_bit_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_a;
  logic [23:0] req_b;
  logic [5:0]  add_a;
  logic [5:0]  add_b;
  logic [5:0]  add_sum;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_sum;
  logic        busy;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  adder_6_bit_sched #(.NUM_REQ(4), .WIDTH(6), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .ops_done(ops_done)
  );

  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [5:0] b);
    req_a[i*6 +: 6] = a;
    req_b[i*6 +: 6] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    step(); step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops got %0d exp 0", ops_done); end
    checks++; if (rsp_sum !== 6'd0 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp got sum %0d id %0d exp 0 0", rsp_sum, rsp_id); end
    checks++; if (add_a !== 6'd0 || add_b !== 6'd0) begin errors++; $display("FAIL reset_add got %0d %0d exp 0 0", add_a, add_b); end
    req_valid = 4'b0000;
    rst_n = 1'b1;
    step();
    $display("reset done");
  endtask

  task automatic test_basic();
    set_req(0, 6'd25, 6'd17);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (add_a !== 6'd25 || add_b !== 6'd17) begin errors++; $display("FAIL basic_add got %0d %0d exp 25 17", add_a, add_b); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_calc got valid %b busy %b exp 0 1", rsp_valid, busy); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 6'd42 || rsp_id !== 2'd0) begin errors++; $display("FAIL basic_rsp got v %b sum %0d id %0d exp 1 42 0", rsp_valid, rsp_sum, rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; exp_ops++;
    checks++; if (rsp_valid !== 1'b0 || ops_done !== 16'(exp_ops)) begin errors++; $display("FAIL basic_done got v %b ops %0d exp 0 %0d", rsp_valid, ops_done, exp_ops); end
    $display("basic op 25+17 done");
  endtask

  task automatic test_sparse();
    set_req(0, 6'd3, 6'd4);
    set_req(3, 6'd30, 6'd31);
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_ready1 got %b exp 1000", req_ready); end
    step();
    req_valid = 4'b0001;
    checks++; if (add_a !== 6'd30) begin errors++; $display("FAIL sparse_add got %0d exp 30", add_a); end
    step();
    checks++; if (rsp_id !== 2'd3 || rsp_sum !== 6'd61) begin errors++; $display("FAIL sparse_rsp1 got id %0d sum %0d exp 3 61", rsp_id, rsp_sum); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; exp_ops++;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sparse_ready2 got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (rsp_id !== 2'd0 || rsp_sum !== 6'd7) begin errors++; $display("FAIL sparse_rsp2 got id %0d sum %0d exp 0 7", rsp_id, rsp_sum); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; exp_ops++;
    checks++; if (ops_done !== 16'(exp_ops)) begin errors++; $display("FAIL sparse_ops got %0d exp %0d", ops_done, exp_ops); end
    $display("sparse grants 3 then 0 done");
  endtask

  task automatic test_overflow();
    logic [5:0] va [2];
    logic [5:0] vb [2];
    logic [5:0] vs [2];
    va[0] = 6'd63; vb[0] = 6'd1;  vs[0] = 6'd0;
    va[1] = 6'd40; vb[1] = 6'd40; vs[1] = 6'd16;
    for (int t = 0; t < 2; t++) begin
      set_req(2, va[t], vb[t]);
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ovf_ready%0d got %b exp 0100", t, req_ready); end
      step();
      req_valid = 4'b0000;
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== vs[t] || rsp_id !== 2'd2) begin errors++; $display("FAIL ovf_rsp%0d got v %b sum %0d id %0d exp 1 %0d 2", t, rsp_valid, rsp_sum, rsp_id, vs[t]); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0; exp_ops++;
      $display("overflow %0d+%0d -> %0d", va[t], vb[t], rsp_sum);
    end
  endtask

  task automatic test_backpressure();
    set_req(1, 6'd10, 6'd20);
    set_req(0, 6'd1, 6'd1);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0001;
    step();
    for (int c = 0; c < 10; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 6'd30 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1)
        begin errors++; $display("FAIL stall%0d got v %b sum %0d id %0d rdy %b busy %b exp 1 30 1 0000 1", c, rsp_valid, rsp_sum, rsp_id, req_ready, busy); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 4'b0000; exp_ops++;
    checks++; if (rsp_valid !== 1'b0 || ops_done !== 16'(exp_ops)) begin errors++; $display("FAIL bp_done got v %b ops %0d exp 0 %0d", rsp_valid, ops_done, exp_ops); end
    step(); step();
    checks++; if (ops_done !== 16'(exp_ops) || busy !== 1'b0) begin errors++; $display("FAIL bp_single got ops %0d busy %b exp %0d 0", ops_done, busy, exp_ops); end
    $display("backpressure 10 cycles, one handshake");
  endtask

  task automatic test_reset_mid_calc();
    set_req(2, 6'd5, 6'd6);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1111;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_calc got busy %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0 || add_a !== 6'd0 || req_ready !== 4'b0000)
      begin errors++; $display("FAIL midrst_now got v %b busy %b ops %0d add %0d rdy %b exp 0 0 0 0 0000", rsp_valid, busy, ops_done, add_a, req_ready); end
    req_valid = 4'b0000;
    step();
    rst_n = 1'b1; exp_ops = 0;
    step(); step();
    checks++; if (rsp_valid !== 1'b0 || ops_done !== 16'd0) begin errors++; $display("FAIL midrst_after got v %b ops %0d exp 0 0", rsp_valid, ops_done); end
    $display("reset mid-calc discarded op");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    logic [5:0] exp_sum;
    for (int i = 0; i < 4; i++) set_req(i, 6'(10 * i + 1), 6'(5 + i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      exp_id = 2'(n % 4);
      exp_sum = 6'(10 * (n % 4) + 1 + 5 + (n % 4));
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_grant%0d got %b exp id %0d", n, req_ready, exp_id); end
      step();
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== exp_sum) begin errors++; $display("FAIL rr_rsp%0d got v %b id %0d sum %0d exp 1 %0d %0d", n, rsp_valid, rsp_id, rsp_sum, exp_id, exp_sum); end
      step();
      $display("rr op %0d id %0d sum %0d", n, rsp_id, rsp_sum);
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    checks++; if (ops_done !== 16'd8) begin errors++; $display("FAIL rr_ops got %0d exp 8", ops_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_round_robin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_6_bit_sched.md
# adder_6_bit_sched

Round-robin scheduler that shares one combinational `adder_6_bit` instance among `NUM_REQ` requesters in the vedic multiplier datapath. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester, registers its operands, and drives them into the shared adder. It then registers the modulo-2^WIDTH sum and returns it on a single response channel tagged with the requester index, holding it until the consumer accepts.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 6: operand/sum width; must match the shared adder.
- `IDW`, 2: requester-id width, equal to ceil(log2(NUM_REQ)).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept strobe; one-hot or zero.
- `req_a`  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  operand B; same packing as `req_a`.
- `add_a`  out  WIDTH  to the shared adder's `a` input.
- `add_b`  out  WIDTH  to the shared adder's `b` input.
- `add_sum`  in  WIDTH  from the shared adder's `sum` output (combinational).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_sum`  out  WIDTH  registered sum, (a+b) mod 2^WIDTH; carry is discarded.
- `busy`  out  1  high whenever the state is not IDLE.
- `ops_done`  out  16  count of completed response handshakes; wraps at 2^16.

## Operation
- The FSM has three states: IDLE, CALC and RESP.
- IDLE:
  - Compute grant g = the first i with req_valid[i]=1, searching i = ptr, ptr+1, … mod NUM_REQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - On the accept edge (req_valid[g] & req_ready[g]): capture op_a=req_a[g], op_b=req_b[g], op_id=g; set ptr=(g+1) mod NUM_REQ; go to CALC.
  - If no req_valid is set: stay in IDLE, req_ready=0, ptr unchanged.
- CALC:
  - Drive add_a=op_a and add_b=op_b.
  - Register rsp_sum=add_sum and rsp_id=op_id; set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_sum stable until rsp_ready=1.
  - On the handshake edge: clear rsp_valid, increment ops_done, go to IDLE.
- Outside CALC, add_a and add_b are 0. This prevents spurious toggling of the shared adder.
- req_ready is 0 in every state except IDLE.
- Requesters must hold req_valid and their operands stable until accepted. The scheduler samples operands only on the accept edge.
- A requester that drops req_valid before it is accepted is never granted. This is legal behaviour.
- ptr advances only on an accept. This guarantees every continuously-valid requester is served within NUM_REQ grants.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream) forces:
  - state=IDLE, ptr=0, op_a=op_b=0, op_id=0;
  - rsp_valid=0, rsp_id=0, rsp_sum=0, ops_done=0, busy=0.
- req_ready is combinational and therefore also 0 while rst_n=0. add_a and add_b are 0.
- Reset asserted mid-operation (in CALC or RESP) discards the in-flight operation with no response. There is no partial state after deassertion.
- Latency: accept on edge T → rsp_valid=1 from edge T+1. The response is visible in the cycle after CALC.
- Minimum spacing between accepts is 3 cycles (IDLE, CALC, RESP with rsp_ready=1). A new accept can occur in the cycle after the response handshake.
- rsp_ready held low stalls the FSM in RESP indefinitely. No requests are accepted during the stall.
- rsp_ready asserted while rsp_valid=0 has no effect.
- ops_done wraps from 0xFFFF to 0x0000.

## Test plan
- Reset, then single request 0 with a=6'd25, b=6'd17: req_ready[0]=1 in the same cycle. rsp_valid rises 2 edges later with rsp_sum=6'd42 and rsp_id=0. ops_done=1 after the handshake.
- Overflow: requester 2 with a=6'd63, b=6'd1 → rsp_sum=6'd0, rsp_id=2. Also a=6'd40, b=6'd40 → rsp_sum=6'd16.
- All four requesters valid continuously with rsp_ready=1: grant order is 0,1,2,3,0,… Each response id matches its grant, one accept every 3 cycles. After 8 ops, ops_done=8.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP. rsp_sum and rsp_id stay stable, req_ready stays all-zero and busy=1. Raising rsp_ready completes exactly one handshake.
- Sparse round-robin: ptr=1 after serving requester 0; only requesters 0 and 3 valid → grant 3, then 0.
- Reset mid-CALC: assert rst_n=0. rsp_valid=0 and ptr=0 immediately. No response for the in-flight op, and ops_done=0 after release.
